// File: rtl/grf_w_sink.sv
// grf_w_sink: general-purpose register file terminating the write-back stage.
// Two combinational read ports with an optional same-cycle W->D bypass.
// It also keeps a retired-write counter and a record of the last committed write.
// Optional build macro GRF_TRACE_EN prints one line for each committed write.
// It is simulation only. Without it, no display code is compiled.
module grf_w_sink #(
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int DW     = 32,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          RegWrite_W,
  input  logic [AW-1:0] A3_W,
  input  logic [DW-1:0] WD_W,
  input  logic [31:0]   PC4_W,
  input  logic [AW-1:0] A1_D,
  input  logic [AW-1:0] A2_D,
  output logic [DW-1:0] RD1_D,
  output logic [DW-1:0] RD2_D,
  output logic [31:0]   wr_cnt,
  output logic [31:0]   last_wpc,
  output logic [AW-1:0] last_a3,
  output logic [DW-1:0] last_wd
);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];
  logic [31:0]   wr_cnt_q, wr_cnt_d;
  logic [31:0]   last_wpc_q, last_wpc_d;
  logic [AW-1:0] last_a3_q, last_a3_d;
  logic [DW-1:0] last_wd_q, last_wd_d;
  logic          commit;

  // A write commits only with a non-zero address, so $0 stays zero.
  // When that happens, the counter and the last-write record advance together.
  always_comb begin
    regs_d     = regs_q;
    wr_cnt_d   = wr_cnt_q;
    last_wpc_d = last_wpc_q;
    last_a3_d  = last_a3_q;
    last_wd_d  = last_wd_q;
    commit     = RegWrite_W && (A3_W != '0);
    if (commit) begin
      regs_d[A3_W] = WD_W;
      wr_cnt_d     = wr_cnt_q + 32'd1;
      last_wpc_d   = PC4_W - 32'd4;
      last_a3_d    = A3_W;
      last_wd_d    = WD_W;
    end
    regs_d[0] = '0;
  end

  // Synchronous active-low reset clears all state and discards a concurrent write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      regs_q     <= '{default: '0};
      wr_cnt_q   <= '0;
      last_wpc_q <= '0;
      last_a3_q  <= '0;
      last_wd_q  <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_cnt_q   <= wr_cnt_d;
      last_wpc_q <= last_wpc_d;
      last_a3_q  <= last_a3_d;
      last_wd_q  <= last_wd_d;
    end
  end

`ifdef GRF_TRACE_EN
  // Commit trace, printed on the same edge that updates the storage.
  always_ff @(posedge clk) begin
    if (reset && commit)
      $display("@%h: $%d <= %h", PC4_W - 32'd4, A3_W, WD_W);
  end
`endif

  // Read port 1. The bypass is not gated by reset; the D stage is flushed by that reset.
  always_comb begin
    if (A1_D == '0)
      RD1_D = '0;
    else if ((BYPASS != 0) && RegWrite_W && (A3_W == A1_D))
      RD1_D = WD_W;
    else
      RD1_D = regs_q[A1_D];
  end

  // Read port 2. It resolves independently of port 1.
  always_comb begin
    if (A2_D == '0)
      RD2_D = '0;
    else if ((BYPASS != 0) && RegWrite_W && (A3_W == A2_D))
      RD2_D = WD_W;
    else
      RD2_D = regs_q[A2_D];
  end

  assign wr_cnt   = wr_cnt_q;
  assign last_wpc = last_wpc_q;
  assign last_a3  = last_a3_q;
  assign last_wd  = last_wd_q;

endmodule

// File: tb/tb_grf_w_sink.sv
// Directed testbench for grf_w_sink.
// It runs one instance with the bypass enabled and one with it disabled, both driven by the same stimulus.
module tb_grf_w_sink;

  logic        clk;
  logic        reset;
  logic        RegWrite_W;
  logic [4:0]  A3_W;
  logic [31:0] WD_W;
  logic [31:0] PC4_W;
  logic [4:0]  A1_D;
  logic [4:0]  A2_D;

  logic [31:0] RD1_D, RD2_D, wr_cnt, last_wpc, last_wd;
  logic [4:0]  last_a3;
  logic [31:0] nb_RD1_D, nb_RD2_D, nb_wr_cnt, nb_last_wpc, nb_last_wd;
  logic [4:0]  nb_last_a3;

  int checks;
  int errors;

  grf_w_sink #(.NREG(32), .AW(5), .DW(32), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .RegWrite_W(RegWrite_W), .A3_W(A3_W), .WD_W(WD_W),
    .PC4_W(PC4_W), .A1_D(A1_D), .A2_D(A2_D), .RD1_D(RD1_D), .RD2_D(RD2_D),
    .wr_cnt(wr_cnt), .last_wpc(last_wpc), .last_a3(last_a3), .last_wd(last_wd)
  );

  grf_w_sink #(.NREG(32), .AW(5), .DW(32), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .RegWrite_W(RegWrite_W), .A3_W(A3_W), .WD_W(WD_W),
    .PC4_W(PC4_W), .A1_D(A1_D), .A2_D(A2_D), .RD1_D(nb_RD1_D), .RD2_D(nb_RD2_D),
    .wr_cnt(nb_wr_cnt), .last_wpc(nb_last_wpc), .last_a3(nb_last_a3), .last_wd(nb_last_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then step 1 time unit past it so that inputs change and outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite_W = 1'b0;
    A3_W = 5'd0;
    WD_W = 32'd0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    PC4_W = 32'd0;
    tick();
    reset = 1'b1;
    A1_D = 5'd5;
    A2_D = 5'd31;
    #1;
    checks++; if (RD1_D !== 32'd0) begin errors++; $display("FAIL reset_rd1 got %h exp %h", RD1_D, 32'd0); end
    checks++; if (RD2_D !== 32'd0) begin errors++; $display("FAIL reset_rd2 got %h exp %h", RD2_D, 32'd0); end
    checks++; if (wr_cnt !== 32'd0) begin errors++; $display("FAIL reset_wr_cnt got %h exp %h", wr_cnt, 32'd0); end
    checks++; if (last_wpc !== 32'd0) begin errors++; $display("FAIL reset_last_wpc got %h exp %h", last_wpc, 32'd0); end
    checks++; if (last_a3 !== 5'd0) begin errors++; $display("FAIL reset_last_a3 got %0d exp %0d", last_a3, 0); end
  endtask

  task automatic test_basic_write();
    RegWrite_W = 1'b1; A3_W = 5'd8; WD_W = 32'h12345678; PC4_W = 32'h3004;
    tick();
    idle();
    A1_D = 5'd8;
    A2_D = 5'd7;
    #1;
    checks++; if (RD1_D !== 32'h12345678) begin errors++; $display("FAIL basic_rd1 got %h exp %h", RD1_D, 32'h12345678); end
    checks++; if (RD2_D !== 32'd0) begin errors++; $display("FAIL basic_rd2_other got %h exp %h", RD2_D, 32'd0); end
    checks++; if (wr_cnt !== 32'd1) begin errors++; $display("FAIL basic_wr_cnt got %h exp %h", wr_cnt, 32'd1); end
    checks++; if (last_wpc !== 32'h3000) begin errors++; $display("FAIL basic_last_wpc got %h exp %h", last_wpc, 32'h3000); end
    checks++; if (last_a3 !== 5'd8) begin errors++; $display("FAIL basic_last_a3 got %0d exp %0d", last_a3, 8); end
    checks++; if (last_wd !== 32'h12345678) begin errors++; $display("FAIL basic_last_wd got %h exp %h", last_wd, 32'h12345678); end
  endtask

  task automatic test_bypass();
    RegWrite_W = 1'b1; A3_W = 5'd9; WD_W = 32'h1; PC4_W = 32'h3008;
    tick();
    RegWrite_W = 1'b1; A3_W = 5'd9; WD_W = 32'hAAAA; PC4_W = 32'h3010;
    A1_D = 5'd9; A2_D = 5'd9;
    #1;
    checks++; if (RD1_D !== 32'hAAAA) begin errors++; $display("FAIL bypass_rd1 got %h exp %h", RD1_D, 32'hAAAA); end
    checks++; if (RD2_D !== 32'hAAAA) begin errors++; $display("FAIL bypass_rd2 got %h exp %h", RD2_D, 32'hAAAA); end
    checks++; if (nb_RD1_D !== 32'h1) begin errors++; $display("FAIL nobypass_rd1_pre got %h exp %h", nb_RD1_D, 32'h1); end
    checks++; if (nb_RD2_D !== 32'h1) begin errors++; $display("FAIL nobypass_rd2_pre got %h exp %h", nb_RD2_D, 32'h1); end
    tick();
    idle();
    #1;
    checks++; if (nb_RD1_D !== 32'hAAAA) begin errors++; $display("FAIL nobypass_rd1_post got %h exp %h", nb_RD1_D, 32'hAAAA); end
    checks++; if (RD2_D !== 32'hAAAA) begin errors++; $display("FAIL bypass_rd2_post got %h exp %h", RD2_D, 32'hAAAA); end
    checks++; if (wr_cnt !== 32'd3) begin errors++; $display("FAIL bypass_wr_cnt got %h exp %h", wr_cnt, 32'd3); end
    checks++; if (nb_wr_cnt !== 32'd3) begin errors++; $display("FAIL nobypass_wr_cnt got %h exp %h", nb_wr_cnt, 32'd3); end
  endtask

  task automatic test_zero_write();
    RegWrite_W = 1'b1; A3_W = 5'd0; WD_W = 32'hFFFFFFFF; PC4_W = 32'h5000;
    A1_D = 5'd0; A2_D = 5'd9;
    #1;
    checks++; if (RD1_D !== 32'd0) begin errors++; $display("FAIL zero_rd1_pre got %h exp %h", RD1_D, 32'd0); end
    tick();
    idle();
    #1;
    checks++; if (RD1_D !== 32'd0) begin errors++; $display("FAIL zero_rd1_post got %h exp %h", RD1_D, 32'd0); end
    checks++; if (RD2_D !== 32'hAAAA) begin errors++; $display("FAIL zero_r9_kept got %h exp %h", RD2_D, 32'hAAAA); end
    checks++; if (wr_cnt !== 32'd3) begin errors++; $display("FAIL zero_wr_cnt got %h exp %h", wr_cnt, 32'd3); end
    checks++; if (last_wpc !== 32'h300C) begin errors++; $display("FAIL zero_last_wpc got %h exp %h", last_wpc, 32'h300C); end
    checks++; if (last_a3 !== 5'd9) begin errors++; $display("FAIL zero_last_a3 got %0d exp %0d", last_a3, 9); end
    checks++; if (last_wd !== 32'hAAAA) begin errors++; $display("FAIL zero_last_wd got %h exp %h", last_wd, 32'hAAAA); end
  endtask

  task automatic test_idle_x();
    RegWrite_W = 1'b0; A3_W = 5'bx; WD_W = 32'bx; PC4_W = 32'h6004;
    A1_D = 5'd8; A2_D = 5'd9;
    tick();
    #1;
    checks++; if (RD1_D !== 32'h12345678) begin errors++; $display("FAIL idlex_rd1 got %h exp %h", RD1_D, 32'h12345678); end
    checks++; if (RD2_D !== 32'hAAAA) begin errors++; $display("FAIL idlex_rd2 got %h exp %h", RD2_D, 32'hAAAA); end
    checks++; if (wr_cnt !== 32'd3) begin errors++; $display("FAIL idlex_wr_cnt got %h exp %h", wr_cnt, 32'd3); end
    idle();
  endtask

  task automatic test_reset_mid_write();
    RegWrite_W = 1'b1; A3_W = 5'd3; WD_W = 32'h55; PC4_W = 32'h7004;
    tick();
    reset = 1'b0;
    RegWrite_W = 1'b1; A3_W = 5'd3; WD_W = 32'h77; PC4_W = 32'h7008;
    A1_D = 5'd3; A2_D = 5'd8;
    #1;
    checks++; if (RD1_D !== 32'h77) begin errors++; $display("FAIL rstmid_bypass got %h exp %h", RD1_D, 32'h77); end
    tick();
    reset = 1'b1;
    idle();
    #1;
    checks++; if (RD1_D !== 32'd0) begin errors++; $display("FAIL rstmid_r3 got %h exp %h", RD1_D, 32'd0); end
    checks++; if (RD2_D !== 32'd0) begin errors++; $display("FAIL rstmid_r8 got %h exp %h", RD2_D, 32'd0); end
    checks++; if (wr_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_wr_cnt got %h exp %h", wr_cnt, 32'd0); end
    checks++; if (last_wd !== 32'd0) begin errors++; $display("FAIL rstmid_last_wd got %h exp %h", last_wd, 32'd0); end
    checks++; if (last_wpc !== 32'd0) begin errors++; $display("FAIL rstmid_last_wpc got %h exp %h", last_wpc, 32'd0); end
  endtask

  task automatic test_back_to_back();
    RegWrite_W = 1'b1; A3_W = 5'd1;
    WD_W = 32'd1; PC4_W = 32'h104; tick();
    WD_W = 32'd2; PC4_W = 32'h108; tick();
    WD_W = 32'd3; PC4_W = 32'h10C; tick();
    idle();
    A1_D = 5'd1; A2_D = 5'd1;
    #1;
    checks++; if (RD1_D !== 32'd3) begin errors++; $display("FAIL b2b_rd1 got %h exp %h", RD1_D, 32'd3); end
    checks++; if (RD2_D !== 32'd3) begin errors++; $display("FAIL b2b_rd2 got %h exp %h", RD2_D, 32'd3); end
    checks++; if (wr_cnt !== 32'd3) begin errors++; $display("FAIL b2b_wr_cnt got %h exp %h", wr_cnt, 32'd3); end
    checks++; if (last_wpc !== 32'h108) begin errors++; $display("FAIL b2b_last_wpc got %h exp %h", last_wpc, 32'h108); end
  endtask

  task automatic test_pc_zero();
    RegWrite_W = 1'b1; A3_W = 5'd2; WD_W = 32'hBEEF; PC4_W = 32'd0;
    tick();
    idle();
    #1;
    checks++; if (last_wpc !== 32'hFFFFFFFC) begin errors++; $display("FAIL pc0_last_wpc got %h exp %h", last_wpc, 32'hFFFFFFFC); end
    checks++; if (last_a3 !== 5'd2) begin errors++; $display("FAIL pc0_last_a3 got %0d exp %0d", last_a3, 2); end
    checks++; if (wr_cnt !== 32'd4) begin errors++; $display("FAIL pc0_wr_cnt got %h exp %h", wr_cnt, 32'd4); end
  endtask

  task automatic test_wrap();
    force dut.wr_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.wr_cnt_q;
    #1;
    checks++; if (wr_cnt !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_preload got %h exp %h", wr_cnt, 32'hFFFFFFFF); end
    RegWrite_W = 1'b1; A3_W = 5'd4; WD_W = 32'h44; PC4_W = 32'h204;
    tick();
    idle();
    #1;
    checks++; if (wr_cnt !== 32'd0) begin errors++; $display("FAIL wrap_wr_cnt got %h exp %h", wr_cnt, 32'd0); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    idle();
    PC4_W = 32'd0;
    A1_D = 5'd0;
    A2_D = 5'd0;
    test_reset();
    test_basic_write();
    test_bypass();
    test_zero_write();
    test_idle_x();
    test_reset_mid_write();
    test_back_to_back();
    test_pc_zero();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
